// File: rtl/uart_program_loader.sv
// Parses UART program-download frames (start marker, little-endian payload words, end marker)
// and streams the assembled words into instruction memory while holding the core in reset.
module uart_program_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        prog_write_enable,
    output logic [31:0] prog_write_address,
    output logic [31:0] prog_write_data,
    output logic        loading,
    output logic        load_done,
    output logic        frame_error,
    output logic [31:0] word_count
);
    localparam int unsigned WORD_W = 32;
    // Start window keeps the oldest byte in the MSB; the end marker is a little-endian word.
    localparam logic [WORD_W-1:0] START_MARKER = 32'h5aa5_0ff0;
    localparam logic [WORD_W-1:0] END_MARKER   = 32'h5aa5_0ff0;

    typedef enum logic [0:0] {HUNT, LOAD} state_t;

    state_t            state, state_next;
    logic [WORD_W-1:0] shift, shift_next;
    logic [1:0]        byte_idx, byte_idx_next;
    logic [WORD_W-1:0] timer, timer_next;
    logic              write_enable_next;
    logic [WORD_W-1:0] write_address_next;
    logic [WORD_W-1:0] write_data_next;
    logic              loading_next;
    logic              load_done_next;
    logic              frame_error_next;
    logic [WORD_W-1:0] word_count_next;
    logic [WORD_W-1:0] window_in;
    logic [WORD_W-1:0] word_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= HUNT;
            shift              <= '0;
            byte_idx           <= '0;
            timer              <= '0;
            prog_write_enable  <= 1'b0;
            prog_write_address <= '0;
            prog_write_data    <= '0;
            loading            <= 1'b0;
            load_done          <= 1'b0;
            frame_error        <= 1'b0;
            word_count         <= '0;
        end else begin
            state              <= state_next;
            shift              <= shift_next;
            byte_idx           <= byte_idx_next;
            timer              <= timer_next;
            prog_write_enable  <= write_enable_next;
            prog_write_address <= write_address_next;
            prog_write_data    <= write_data_next;
            loading            <= loading_next;
            load_done          <= load_done_next;
            frame_error        <= frame_error_next;
            word_count         <= word_count_next;
        end
    end

    always_comb begin
        state_next         = state;
        shift_next         = shift;
        byte_idx_next      = byte_idx;
        timer_next         = timer;
        write_enable_next  = 1'b0;
        write_address_next = prog_write_address;
        write_data_next    = prog_write_data;
        loading_next       = loading;
        load_done_next     = 1'b0;
        frame_error_next   = 1'b0;
        word_count_next    = word_count;

        window_in = {shift[23:0], rx_data};
        word_in   = shift;
        case (byte_idx)
            2'd0:    word_in[7:0]   = rx_data;
            2'd1:    word_in[15:8]  = rx_data;
            2'd2:    word_in[23:16] = rx_data;
            default: word_in[31:24] = rx_data;
        endcase

        case (state)
            HUNT: begin
                if (rx_valid) begin
                    shift_next = window_in;
                    if (window_in == START_MARKER) begin
                        state_next      = LOAD;
                        loading_next    = 1'b1;
                        shift_next      = '0;
                        byte_idx_next   = '0;
                        timer_next      = '0;
                        word_count_next = '0;
                    end
                end
            end
            LOAD: begin
                // Timeout wins over a byte arriving on the same cycle.
                if (timer == TIMEOUT_CYCLES) begin
                    state_next       = HUNT;
                    loading_next     = 1'b0;
                    frame_error_next = 1'b1;
                    shift_next       = '0;
                    byte_idx_next    = '0;
                end else if (rx_valid) begin
                    timer_next    = '0;
                    shift_next    = word_in;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        shift_next = '0;
                        if (word_in == END_MARKER) begin
                            state_next     = HUNT;
                            loading_next   = 1'b0;
                            load_done_next = 1'b1;
                        end else if (word_count == WORD_W'(MAX_WORDS)) begin
                            state_next       = HUNT;
                            loading_next     = 1'b0;
                            frame_error_next = 1'b1;
                        end else begin
                            write_enable_next  = 1'b1;
                            write_address_next = BASE_ADDR + (word_count << 2);
                            write_data_next    = word_in;
                            word_count_next    = word_count + 32'd1;
                        end
                    end
                end else begin
                    timer_next = timer + 32'd1;
                end
            end
            default: state_next = HUNT;
        endcase
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: a queue-based frame model predicts writes,
// load_done and frame_error events with their exact cycles; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_uart_program_loader;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam int unsigned MAXW = 3;
    localparam int          TMO  = 100;
    localparam logic [2:0]  K_WR = 3'b001, K_DONE = 3'b010, K_ERR = 3'b100;
    localparam logic [31:0] START_W = 32'hf00f_a55a;  // sends 5a a5 0f f0
    localparam logic [31:0] END_W   = 32'h5aa5_0ff0;  // sends f0 0f a5 5a

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        prog_write_enable;
    logic [31:0] prog_write_address;
    logic [31:0] prog_write_data;
    logic        loading;
    logic        load_done;
    logic        frame_error;
    logic [31:0] word_count;

    uart_program_loader #(
        .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(32'(TMO))
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .prog_write_enable(prog_write_enable), .prog_write_address(prog_write_address),
        .prog_write_data(prog_write_data), .loading(loading), .load_done(load_done),
        .frame_error(frame_error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] count;
        int          due;
    } ev_t;
    ev_t sbq[$];

    logic [7:0] hist[$];
    logic [7:0] cur[$];
    bit         in_frame  = 1'b0;
    int         nwords    = 0;
    int         last_slot = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d,
                                    input logic [31:0] c, input int due);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.count = c; e.due = due;
        sbq.push_back(e);
    endfunction

    function automatic void leave_frame();
        in_frame = 1'b0;
        hist.delete();
        cur.delete();
    endfunction

    // Frame has been idle for TMO+1 slots: the timeout error appears on the next cycle.
    function automatic void model_tick(input int slot);
        if (in_frame && (slot - last_slot) == TMO + 1) begin
            push_ev(K_ERR, 32'h0, 32'h0, 32'(nwords), slot + 1);
            leave_frame();
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int slot);
        logic [31:0] w;
        if (!in_frame) begin
            hist.push_back(b);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && {hist[0], hist[1], hist[2], hist[3]} == 32'h5aa5_0ff0) begin
                in_frame  = 1'b1;
                nwords    = 0;
                last_slot = slot;
                cur.delete();
            end
        end else begin
            last_slot = slot;
            cur.push_back(b);
            if (cur.size() == 4) begin
                w = {cur[3], cur[2], cur[1], cur[0]};
                cur.delete();
                if (w == END_W) begin
                    push_ev(K_DONE, 32'h0, 32'h0, 32'(nwords), slot + 1);
                    leave_frame();
                end else if (nwords == int'(MAXW)) begin
                    push_ev(K_ERR, 32'h0, 32'h0, 32'(nwords), slot + 1);
                    leave_frame();
                end else begin
                    push_ev(K_WR, BASE + 32'(4 * nwords), w, 32'(nwords + 1), slot + 1);
                    nwords++;
                end
            end
        end
    endfunction

    task automatic slot();
        @(negedge clk);
        model_tick(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) slot();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        slot();
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b, cyc);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},    32'(prog_write_enable), 32'h0);
        check({tag, "_addr"},  prog_write_address,     32'h0);
        check({tag, "_data"},  prog_write_data,        32'h0);
        check({tag, "_load"},  32'(loading),           32'h0);
        check({tag, "_done"},  32'(load_done),         32'h0);
        check({tag, "_err"},   32'(frame_error),       32'h0);
        check({tag, "_count"}, word_count,             32'h0);
    endtask

    // Monitor: every DUT event must match the head of the scoreboard on its predicted cycle.
    logic [2:0] mon_kind;
    ev_t        mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                mon_e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL event_missing: kind %b due cycle %0d not seen by cycle %0d",
                         mon_e.kind, mon_e.due, cyc);
            end
            mon_kind = {frame_error, load_done, prog_write_enable};
            if (mon_kind != 3'b000) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL event_unexpected: kind %b at cycle %0d, nothing expected", mon_kind, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("event_kind",  32'(mon_kind), 32'(mon_e.kind));
                    check("event_cycle", 32'(cyc), 32'(mon_e.due));
                    check("event_count", word_count, mon_e.count);
                    check("event_loading", 32'(loading), 32'(mon_e.kind == K_WR));
                    if (mon_e.kind == K_WR) begin
                        check("write_addr", prog_write_address, mon_e.addr);
                        check("write_data", prog_write_data, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int nw;
        int gap;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        idle(2);

        // Two-word frame, back-to-back bytes.
        send_word(START_W, 0);
        send_word(32'h4030_2010, 0);
        send_word(32'h8070_6050, 0);
        send_word(END_W, 0);
        idle(3);
        check("t1_loading", 32'(loading), 32'(in_frame));
        check("t1_word_count", word_count, 32'd2);

        // Sliding sync on a partial marker.
        send_byte(8'h5a, 1);
        send_word(START_W, 0);
        check("t2_loading_after_start", 32'(loading), 32'h1);
        send_word(32'h4433_2211, 1);
        send_word(END_W, 2);
        idle(3);
        check("t2_word_count", word_count, 32'd1);

        // Timeout after two payload bytes.
        send_word(START_W, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 3);
        idle(TMO + 20);
        check("t3_loading", 32'(loading), 32'h0);
        check("t3_word_count", word_count, 32'd0);

        // Overflow on the word after MAXW.
        send_word(START_W, 0);
        for (int i = 0; i < int'(MAXW) + 1; i++) send_word(32'hA000_0000 + 32'(i), 1);
        idle(3);
        check("t4_loading", 32'(loading), 32'h0);
        check("t4_word_count", word_count, 32'(MAXW));

        // Asynchronous reset mid-frame, then a clean frame from BASE.
        send_word(START_W, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero("midframe_reset");
        leave_frame();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_word(START_W, 1);
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'h0BAD_F00D, 0);
        send_word(END_W, 0);
        idle(3);
        check("t5_word_count", word_count, 32'd2);

        // End marker while hunting is ignored.
        send_word(END_W, 0);
        idle(3);
        check("t6_loading", 32'(loading), 32'h0);
        check("t6_word_count", word_count, 32'd2);

        // Randomized frames with junk prefixes and inter-byte gaps.
        for (int f = 0; f < 25; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                send_byte(8'($urandom()), int'($urandom_range(0, 2)));
            gap = int'($urandom_range(0, 3));
            send_word(START_W, gap);
            nw = int'($urandom_range(0, MAXW + 1));
            for (int k = 0; k < nw; k++) begin
                w = $urandom();
                if (w == END_W) w = w ^ 32'h1;
                send_word(w, int'($urandom_range(0, 3)));
            end
            send_word(END_W, int'($urandom_range(0, 3)));
            idle(2);
            check("rand_loading", 32'(loading), 32'(in_frame));
        end

        idle(5);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
